// File: rtl/program_loader.sv
// program_loader: boot sequencer for a small processor core.
// Clears the register file, streams a program into instruction memory,
// holds the core in reset for a fixed number of cycles, then runs it for a
// cycle budget (or until stopped) while counting elapsed run cycles.
//
// Ports
//   clk, reset        : clock, asynchronous active-low reset
//   start, stop       : begin boot sequence / end run early
//   ld_valid/ld_data/ld_last, ld_ready : program load stream (valid/ready)
//   imem_we/imem_addr/imem_wdata       : instruction-memory write port
//   rf_we/rf_addr/rf_wdata             : register-file clear port
//   core_reset        : active-high reset to the core (low only in RUN)
//   cycle_count       : RUN cycles elapsed (saturating)
//   busy, done, error : status flags
module program_loader #(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned AWIDTH     = 32,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned RESET_HOLD = 2,
    parameter int unsigned RUN_CYCLES = 95,
    localparam int unsigned RW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              ld_valid,
    input  logic [DWIDTH-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [AWIDTH-1:0] imem_addr,
    output logic [DWIDTH-1:0] imem_wdata,
    output logic              rf_we,
    output logic [RW-1:0]     rf_addr,
    output logic [DWIDTH-1:0] rf_wdata,
    output logic              core_reset,
    output logic [31:0]       cycle_count,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Word counter must be able to reach IMEM_DEPTH to detect overflow.
    localparam int unsigned WCW = $clog2(IMEM_DEPTH + 1);
    localparam int unsigned HCW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR_RF,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [RW-1:0]    rf_cnt_q, rf_cnt_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [31:0]      cycle_cnt_q, cycle_cnt_d;
    logic             imem_we_c;

    logic ld_ready_q, rf_we_q, core_reset_q, busy_q, done_q, error_q;

    // State and counter registers; status flags are decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rf_cnt_q     <= '0;
            word_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            ld_ready_q   <= 1'b0;
            rf_we_q      <= 1'b0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_cnt_q     <= rf_cnt_d;
            word_cnt_q   <= word_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            ld_ready_q   <= (state_d == S_LOAD);
            rf_we_q      <= (state_d == S_CLR_RF);
            core_reset_q <= (state_d != S_RUN);
            busy_q       <= (state_d == S_CLR_RF) || (state_d == S_LOAD) ||
                            (state_d == S_HOLD)   || (state_d == S_RUN);
            done_q       <= (state_d == S_DONE);
            error_q      <= (state_d == S_ERR);
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        rf_cnt_d    = rf_cnt_q;
        word_cnt_d  = word_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        imem_we_c   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d     = S_CLR_RF;
                    rf_cnt_d    = '0;
                    word_cnt_d  = '0;
                    hold_cnt_d  = '0;
                    cycle_cnt_d = '0;
                end
            end
            S_CLR_RF: begin
                if (rf_cnt_q == RW'(NUM_REGS - 1)) begin
                    state_d = S_LOAD;
                end else begin
                    rf_cnt_d = rf_cnt_q + RW'(1);
                end
            end
            S_LOAD: begin
                // A valid word with memory already full is an overflow, not a write.
                if (ld_valid) begin
                    if (word_cnt_q == WCW'(IMEM_DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        imem_we_c  = 1'b1;
                        word_cnt_d = word_cnt_q + WCW'(1);
                        if (ld_last) begin
                            state_d = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HCW'(RESET_HOLD - 1)) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            S_RUN: begin
                // The current cycle is counted whether the run ends by stop or budget.
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + 32'd1;
                end
                if (stop) begin
                    state_d = S_DONE;
                end else if ((RUN_CYCLES != 0) && (cycle_cnt_q == 32'(RUN_CYCLES - 1))) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ld_ready    = ld_ready_q;
    assign imem_we     = imem_we_c;
    assign imem_addr   = AWIDTH'(word_cnt_q);
    assign imem_wdata  = ld_data;
    assign rf_we       = rf_we_q;
    assign rf_addr     = rf_cnt_q;
    assign rf_wdata    = '0;
    assign core_reset  = core_reset_q;
    assign cycle_count = cycle_cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: instance A (IMEM_DEPTH=4, RUN_CYCLES=95) covers
// nominal boot, backpressure, overflow, reset mid-load and restart; instance B
// (RUN_CYCLES=0, NUM_REGS=8, RESET_HOLD=1) covers unlimited run with early stop.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset, start_a, start_b, stop, ld_valid, ld_last;
    logic [31:0] ld_data;

    logic        ld_ready_a, imem_we_a, rf_we_a, core_reset_a, busy_a, done_a, error_a;
    logic [31:0] imem_addr_a, imem_wdata_a, rf_wdata_a, cycle_count_a;
    logic [4:0]  rf_addr_a;

    logic        ld_ready_b, imem_we_b, rf_we_b, core_reset_b, busy_b, done_b, error_b;
    logic [31:0] imem_addr_b, imem_wdata_b, rf_wdata_b, cycle_count_b;
    logic [2:0]  rf_addr_b;

    always #5 clk = ~clk;

    program_loader #(
        .DWIDTH(32), .AWIDTH(32), .IMEM_DEPTH(4), .NUM_REGS(32),
        .RESET_HOLD(2), .RUN_CYCLES(95)
    ) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stop(stop),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready_a),
        .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
        .rf_we(rf_we_a), .rf_addr(rf_addr_a), .rf_wdata(rf_wdata_a),
        .core_reset(core_reset_a), .cycle_count(cycle_count_a),
        .busy(busy_a), .done(done_a), .error(error_a)
    );

    program_loader #(
        .DWIDTH(32), .AWIDTH(32), .IMEM_DEPTH(256), .NUM_REGS(8),
        .RESET_HOLD(1), .RUN_CYCLES(0)
    ) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready_b),
        .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
        .rf_we(rf_we_b), .rf_addr(rf_addr_b), .rf_wdata(rf_wdata_b),
        .core_reset(core_reset_b), .cycle_count(cycle_count_b),
        .busy(busy_b), .done(done_b), .error(error_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observations of instance A, captured mid-cycle by the monitor only.
    logic [63:0] obs_im[$];
    logic [4:0]  obs_rf[$];
    int          low_n  = 0;
    int          hold_n = 0;

    // Expected writes, pushed as stimulus is driven.
    logic [63:0] exp_im[$];
    logic [4:0]  exp_rf[$];
    int          im_rd = 0;
    int          rf_rd = 0;

    logic [31:0] words [4] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_006F};

    always @(negedge clk) begin
        if (imem_we_a) obs_im.push_back({imem_addr_a, imem_wdata_a});
        if (rf_we_a)   obs_rf.push_back(rf_addr_a);
        if (!core_reset_a) low_n++;
        if (busy_a && core_reset_a && !rf_we_a && !ld_ready_a) hold_n++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rf(input int n);
        for (int i = 0; i < n; i++) exp_rf.push_back(5'(i));
    endtask

    // Compare all observed writes since the last drain against the expectations.
    task automatic drain(input string tag);
        int n_im, n_rf;
        n_im = obs_im.size() - im_rd;
        n_rf = obs_rf.size() - rf_rd;
        chk({tag, "_im_count"}, 64'(n_im), 64'(exp_im.size()));
        chk({tag, "_rf_count"}, 64'(n_rf), 64'(exp_rf.size()));
        while (exp_im.size() > 0) begin
            if (im_rd < obs_im.size()) begin
                chk({tag, "_im_write"}, obs_im[im_rd], exp_im[0]);
                im_rd++;
            end
            void'(exp_im.pop_front());
        end
        while (exp_rf.size() > 0) begin
            if (rf_rd < obs_rf.size()) begin
                chk({tag, "_rf_addr"}, 64'(obs_rf[rf_rd]), 64'(exp_rf[0]));
                rf_rd++;
            end
            void'(exp_rf.pop_front());
        end
        im_rd = obs_im.size();
        rf_rd = obs_rf.size();
    endtask

    task automatic wait_ready_a(input string tag);
        for (int n = 0; n < 100 && !ld_ready_a; n++) tick();
        chk(tag, 64'(ld_ready_a), 64'd1);
    endtask

    task automatic wait_done_a(input string tag);
        for (int n = 0; n < 400 && !done_a; n++) tick();
        chk(tag, 64'(done_a), 64'd1);
    endtask

    initial begin
        int low0, hold0, n, rfb;
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; stop = 1'b0;
        ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_flags_a", 64'({core_reset_a, busy_a, done_a, error_a, ld_ready_a, rf_we_a, imem_we_a}), 64'b1000000);
        chk("rst_cnt_a", 64'(cycle_count_a), 64'd0);
        chk("rst_addr_a", 64'({rf_addr_a, imem_addr_a}), 64'd0);
        chk("rst_flags_b", 64'({core_reset_b, busy_b, done_b, error_b}), 64'b1000);
        #2 reset = 1'b1;
        tick();
        chk("idle_a", 64'({busy_a, core_reset_a}), 64'b01);

        // Nominal boot with valid toggling 1,0,1,0
        push_rf(32);
        low0 = low_n; hold0 = hold_n;
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("start_busy_a", 64'({busy_a, rf_we_a, rf_addr_a}), 64'({1'b1, 1'b1, 5'd0}));
        wait_ready_a("nom_ready");
        for (int i = 0; i < 4; i++) begin
            exp_im.push_back({32'(i), words[i]});
            ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 3);
            tick();
            ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'hDEAD_BEEF;
            tick();
        end
        wait_done_a("nom_done");
        chk("nom_run_cycles", 64'(low_n - low0), 64'd95);
        chk("nom_hold_cycles", 64'(hold_n - hold0), 64'd2);
        chk("nom_cycle_count", 64'(cycle_count_a), 64'd95);
        chk("nom_end_flags", 64'({core_reset_a, busy_a, error_a}), 64'b100);
        drain("nom");

        // Restart from DONE, then overflow with 5 words and no last
        push_rf(32);
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("restart_cnt", 64'(cycle_count_a), 64'd0);
        chk("restart_flags", 64'({busy_a, done_a}), 64'b10);
        wait_ready_a("ovf_ready");
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_im.push_back({32'(i), 32'hA000_0000 + 32'(i)});
            ld_valid = 1'b1; ld_data = 32'hA000_0000 + 32'(i); ld_last = 1'b0;
            tick();
        end
        ld_valid = 1'b0;
        chk("ovf_flags", 64'({error_a, core_reset_a, busy_a, ld_ready_a}), 64'b1100);
        repeat (3) tick();
        chk("ovf_hold", 64'({error_a, core_reset_a, done_a}), 64'b110);
        drain("ovf");

        // Reset in the middle of LOAD after two words
        push_rf(32);
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_ready_a("rml_ready");
        for (int i = 0; i < 2; i++) begin
            exp_im.push_back({32'(i), words[i]});
            ld_valid = 1'b1; ld_data = words[i]; ld_last = 1'b0;
            tick();
        end
        ld_data = words[2];
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rml_flags", 64'({core_reset_a, busy_a, ld_ready_a, imem_we_a}), 64'b1000);
        chk("rml_addr", 64'(imem_addr_a), 64'd0);
        repeat (2) @(posedge clk);
        ld_valid = 1'b0;
        #3 reset = 1'b1;
        drain("rml");
        tick();
        push_rf(32);
        exp_im.push_back({32'd0, words[3]});
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_ready_a("rml2_ready");
        ld_valid = 1'b1; ld_data = words[3]; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        wait_done_a("rml2_done");
        chk("rml2_cycle_count", 64'(cycle_count_a), 64'd95);
        drain("rml2");

        // Instance B: 8-entry clear, single-cycle hold, unlimited run, early stop
        start_b = 1'b1; tick(); start_b = 1'b0;
        rfb = 0;
        for (n = 0; n < 100 && !ld_ready_b; n++) begin
            if (rf_we_b) rfb++;
            tick();
        end
        chk("b_rf_clears", 64'(rfb), 64'd8);
        ld_valid = 1'b1; ld_data = words[1]; ld_last = 1'b1;
        #1;
        chk("b_imem_write", {31'(imem_we_b), imem_addr_b[0], imem_wdata_b}, {31'd1, 1'b0, words[1]});
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        n = 0;
        while (core_reset_b && n < 50) begin
            n++;
            tick();
        end
        chk("b_hold_cycles", 64'(n), 64'd1);
        chk("b_run_start", 64'({core_reset_b, cycle_count_b}), 64'd0);
        repeat (9) tick();
        chk("b_run_10th", 64'(cycle_count_b), 64'd9);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("b_stop_flags", 64'({done_b, core_reset_b, busy_b}), 64'b110);
        chk("b_stop_count", 64'(cycle_count_b), 64'd10);
        repeat (3) tick();
        chk("b_stop_hold", 64'({done_b, cycle_count_b}), {31'd0, 1'b1, 32'd10});
        chk("a_quiet", 64'(obs_im.size() - im_rd), 64'd0);
        chk("a_done_kept", 64'({done_a, cycle_count_a}), {31'd0, 1'b1, 32'd95});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
